// File: rtl/tt_um_hoene_manchester_encoder.sv
// Retransmit stage: buffers decoded bits in a small FIFO and re-encodes them as an
// IEEE Manchester line, reusing the half-bit width measured upstream.
module tt_um_hoene_manchester_encoder #(
    parameter int   FIFO_DEPTH   = 4,
    parameter int   DEFAULT_HALF = 16,
    parameter int   MIN_HALF     = 2,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_data,
    input  logic                        in_clk,
    input  logic [5:0]                  in_pulsewidth,
    input  logic                        in_error,
    input  logic                        swap,
    output logic                        out,
    output logic                        tx_active,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FIRST_HALF,
        SECOND_HALF
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  hw_q, hw_d;
    logic [5:0]  hwSel;
    logic        bit_q, bit_d;
    logic        out_q, out_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic        fifoMem_q [FIFO_DEPTH];
    logic        empty, full, pop, push, headBit;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wrPtr_q == rdPtr_q);
    assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign headBit = fifoMem_q[rdPtr_q[AW-1:0]];

    assign hwSel = (in_pulsewidth == 6'd0)          ? 6'(DEFAULT_HALF) :
                   (in_pulsewidth < 6'(MIN_HALF))   ? 6'(MIN_HALF)     :
                                                      in_pulsewidth;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hw_d    = hw_q;
        bit_d   = bit_q;
        out_d   = out_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hw_d    = hwSel;
                    cnt_d   = hwSel - 6'd1;
                    bit_d   = headBit;
                    out_d   = ~headBit;
                    state_d = FIRST_HALF;
                end
            end
            FIRST_HALF: begin
                if (cnt_q == 6'd0) begin
                    state_d = SECOND_HALF;
                    cnt_d   = hw_q - 6'd1;
                    out_d   = bit_q;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            SECOND_HALF: begin
                // The last cycle of a bit chains straight into the next queued bit.
                if (cnt_q == 6'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        cnt_d   = hw_q - 6'd1;
                        bit_d   = headBit;
                        out_d   = ~headBit;
                        state_d = FIRST_HALF;
                    end else begin
                        state_d = IDLE;
                        out_d   = IDLE_LEVEL;
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = IDLE_LEVEL;
            end
        endcase
        if (in_error) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            out_d   = IDLE_LEVEL;
            pop     = 1'b0;
        end
    end

    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    always_comb begin
        push       = in_clk && !in_error && (!full || pop);
        overflow_d = overflow_q | (in_clk & ~in_error & full & ~pop);
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        if (in_error) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + {{AW{1'b0}}, 1'b1};
            if (pop)  rdPtr_d = rdPtr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            hw_q       <= 6'd0;
            bit_q      <= 1'b0;
            out_q      <= IDLE_LEVEL;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hw_q       <= hw_d;
            bit_q      <= bit_d;
            out_q      <= out_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifoMem_q[wrPtr_q[AW-1:0]] <= in_data ^ swap;
    end

    assign out        = out_q;
    assign tx_active  = (state_q != IDLE);
    assign fifo_count = wrPtr_q - rdPtr_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Bench for the Manchester retransmit stage: a queue-based line model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_tt_um_hoene_manchester_encoder;

    localparam int CLK_HALF = 5;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_data = 1'b0;
    logic       in_clk = 1'b0;
    logic [5:0] in_pulsewidth = 6'd4;
    logic       in_error = 1'b0;
    logic       swap = 1'b0;
    logic       out;
    logic       tx_active;
    logic [2:0] fifo_count;
    logic       overflow;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    bit       sRst, sClk, sData, sErr, sSwap;
    bit [5:0] sPw;

    bit fifoM[$];
    bit lineM[$];
    int hwM = 16;
    bit outM, actM, ovfM;

    bit outLog[$];
    bit txLog[$];
    bit ovfLog[$];
    int cntLog[$];

    always #CLK_HALF clk = ~clk;

    tt_um_hoene_manchester_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_clk        (in_clk),
        .in_pulsewidth (in_pulsewidth),
        .in_error      (in_error),
        .swap          (swap),
        .out           (out),
        .tx_active     (tx_active),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    function automatic int halfWidth(input bit [5:0] pw);
        if (pw == 6'd0) return 16;
        if (pw < 6'd2)  return 2;
        return int'(pw);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The model holds the remaining line levels of the bit in flight as a queue.
    task automatic modelStep();
        bit b;
        if (sRst) begin
            fifoM.delete(); lineM.delete();
            outM = 1'b0; actM = 1'b0; ovfM = 1'b0;
        end else if (sErr) begin
            fifoM.delete(); lineM.delete();
            outM = 1'b0; actM = 1'b0;
        end else begin
            if (lineM.size() > 0) begin
                outM = lineM.pop_front();
            end else if (fifoM.size() > 0) begin
                b = fifoM.pop_front();
                if (!actM) hwM = halfWidth(sPw);
                for (int i = 0; i < hwM; i++) lineM.push_back(~b);
                for (int i = 0; i < hwM; i++) lineM.push_back(b);
                outM = lineM.pop_front();
                actM = 1'b1;
            end else begin
                outM = 1'b0;
                actM = 1'b0;
            end
            if (sClk) begin
                if (fifoM.size() < DEPTH) fifoM.push_back(sData ^ sSwap);
                else ovfM = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        sRst  <= rst;
        sClk  <= in_clk;
        sData <= in_data;
        sErr  <= in_error;
        sSwap <= swap;
        sPw   <= in_pulsewidth;
    end

    always @(negedge clk) begin
        modelStep();
        outLog.push_back(out);
        txLog.push_back(tx_active);
        ovfLog.push_back(overflow);
        cntLog.push_back(int'(fifo_count));
        if (checkEn) begin
            checkOutput("model_out", int'(out), int'(outM));
            checkOutput("model_tx_active", int'(tx_active), int'(actM));
            checkOutput("model_fifo_count", int'(fifo_count), fifoM.size());
            checkOutput("model_overflow", int'(overflow), int'(ovfM));
        end
    end

    task automatic applyStimulus(input bit c, input bit d, input bit s, input bit e,
                                 input bit r, input logic [5:0] pw);
        in_clk = c; in_data = d; swap = s; in_error = e; rst = r; in_pulsewidth = pw;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic [5:0] pw);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pw);
    endtask

    function automatic int packLog(input int base, input int n, input bit useTx);
        int r = 0;
        for (int i = 0; i < n; i++)
            r = (r << 1) | int'(useTx ? txLog[base + i] : outLog[base + i]);
        return r;
    endfunction

    function automatic int sumOut(input int base, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(outLog[base + i]);
        return s;
    endfunction

    initial begin
        int base;
        int peak;
        int waited;

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        checkEn = 1'b1;
        base = outLog.size();
        idleCycles(1, 6'd4);
        checkOutput("reset_out", int'(outLog[base]), 0);
        checkOutput("reset_tx", int'(txLog[base]), 0);
        checkOutput("reset_count", cntLog[base], 0);
        checkOutput("reset_overflow", int'(ovfLog[base]), 0);

        // Single bit 1, half width 4: low four cycles then high four.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4);
        base = outLog.size();
        idleCycles(12, 6'd4);
        checkOutput("single_one_out", packLog(base, 10, 1'b0), 'b0000011110);
        checkOutput("single_one_tx", packLog(base, 10, 1'b1), 'b0111111110);
        checkOutput("single_one_latency_count", cntLog[base], 1);

        // Back-to-back 1,0,1 at half width 3.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3);
        base = outLog.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3);
        idleCycles(22, 6'd3);
        checkOutput("b2b_stream", packLog(base + 1, 18, 1'b0), 'b000111111000000111);
        checkOutput("b2b_tx_span", packLog(base + 1, 19, 1'b1), 'b1111111111111111110);
        peak = 0;
        for (int i = 0; i < 21; i++) if (cntLog[base + i] > peak) peak = cntLog[base + i];
        checkOutput("b2b_peak_count", peak, 2);

        // Zero pulse width falls back to 16-cycle halves.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        base = outLog.size();
        idleCycles(36, 6'd0);
        checkOutput("default_first_half_highs", sumOut(base + 1, 16), 16);
        checkOutput("default_second_half_highs", sumOut(base + 17, 16), 0);
        checkOutput("default_tx_last", int'(txLog[base + 32]), 1);
        checkOutput("default_tx_end", int'(txLog[base + 33]), 0);

        // Width 1 clamps to 2-cycle halves.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1);
        base = outLog.size();
        idleCycles(8, 6'd1);
        checkOutput("clamp_out", packLog(base, 6, 1'b0), 'b000110);
        checkOutput("clamp_tx", packLog(base, 6, 1'b1), 'b011110);

        // Swap turns a pushed 1 into a transmitted 0.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd4);
        base = outLog.size();
        idleCycles(12, 6'd4);
        checkOutput("swap_out", packLog(base, 10, 1'b0), 'b0111100000);
        checkOutput("swap_tx", packLog(base, 10, 1'b1), 'b0111111110);

        // Six pushes in a row at width 10: the sixth overflows.
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 6'd10);
        base = outLog.size();
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 6'd10);
        idleCycles(105, 6'd10);
        checkOutput("ovf_before_sixth", int'(ovfLog[base + 4]), 0);
        checkOutput("ovf_after_sixth", int'(ovfLog[base + 5]), 1);
        checkOutput("ovf_count_full", cntLog[base + 5], 4);
        checkOutput("ovf_stream_last", int'(txLog[base + 100]), 1);
        checkOutput("ovf_stream_end", int'(txLog[base + 101]), 0);

        // Error mid first half with two bits queued.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd10);
        idleCycles(2, 6'd10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd10);
        base = outLog.size();
        idleCycles(3, 6'd10);
        checkOutput("err_pre_out", int'(outLog[base - 1]), 1);
        checkOutput("err_pre_count", cntLog[base - 1], 2);
        checkOutput("err_out", int'(outLog[base]), 0);
        checkOutput("err_count", cntLog[base], 0);
        checkOutput("err_tx", int'(txLog[base]), 0);
        checkOutput("err_overflow_sticky", int'(ovfLog[base]), 1);
        checkOutput("err_push_dropped", cntLog[base + 1], 0);

        // Same scenario, aborted by reset instead.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd10);
        idleCycles(2, 6'd10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd10);
        base = outLog.size();
        idleCycles(3, 6'd10);
        checkOutput("rst_pre_out", int'(outLog[base - 1]), 1);
        checkOutput("rst_out", int'(outLog[base]), 0);
        checkOutput("rst_count", cntLog[base], 0);
        checkOutput("rst_tx", int'(txLog[base]), 0);
        checkOutput("rst_overflow", int'(ovfLog[base]), 0);

        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 249) == 0),
                          ($urandom_range(0, 699) == 0),
                          6'($urandom_range(0, 5)));
        end

        waited = 0;
        while ((tx_active || fifo_count != 3'd0) && waited < 500) begin
            idleCycles(1, 6'd3);
            waited++;
        end
        checkOutput("drain_within_bound", int'(waited < 500), 1);
        idleCycles(2, 6'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
